microarquitetura_gp3_oci_dct_packer: RTL

//  Direction-code trace packer for the Nios II OCI trace path, upstream of the OCI test-bench monitor.

---
 rtl/microarquitetura_gp3_oci_dct_packer_pkg.sv | 23 ++
 rtl/microarquitetura_gp3_oci_dct_packer_if.sv | 23 ++
 rtl/microarquitetura_gp3_oci_dct_pkt_reg.sv | 43 ++++
 rtl/microarquitetura_gp3_oci_dct_packer.sv | 115 +++++++++++
 4 files changed

// File: rtl/microarquitetura_gp3_oci_dct_packer_pkg.sv
// Shared encodings, widths and packet layout for the OCI direction-code trace packer.
package microarquitetura_gp3_oci_dct_packer_pkg;

    localparam int unsigned DCT_DEPTH = 15;
    localparam int unsigned CODE_W    = 2;
    localparam int unsigned BUF_W     = DCT_DEPTH * CODE_W;
    localparam int unsigned CNT_W     = $clog2(DCT_DEPTH + 1);

    typedef enum logic [CODE_W-1:0] {
        DCT_RSV = 2'b00,
        DCT_NT  = 2'b01,
        DCT_TK  = 2'b10,
        DCT_EXC = 2'b11
    } dct_code_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] codes;
    } dct_pkt_t;

    localparam int unsigned PKT_W = $bits(dct_pkt_t);

endpackage

// File: rtl/microarquitetura_gp3_oci_dct_packer_if.sv
// Code-input and packet-output handshakes of the direction-code packer.
interface microarquitetura_gp3_oci_dct_packer_if;
    import microarquitetura_gp3_oci_dct_packer_pkg::*;

    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              code_ready;
    logic              flush_req;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [PKT_W-1:0]  pkt_data;

    modport master (
        output code_valid, code, flush_req, pkt_ready,
        input  code_ready, pkt_valid, pkt_data
    );

    modport slave (
        input  code_valid, code, flush_req, pkt_ready,
        output code_ready, pkt_valid, pkt_data
    );

endinterface

// File: rtl/microarquitetura_gp3_oci_dct_pkt_reg.sv
// One-entry valid/ready holding register; data only changes when the slot is free.
module microarquitetura_gp3_oci_dct_pkt_reg #(
    parameter int unsigned W = 34
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         free_c
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        free_c  = ~valid_q | out_ready;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/microarquitetura_gp3_oci_dct_packer.sv
// Packs 2-bit branch-direction codes into 15-code packets for the OCI trace FIFO.
module microarquitetura_gp3_oci_dct_packer
    import microarquitetura_gp3_oci_dct_packer_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 trc_on,
    microarquitetura_gp3_oci_dct_packer_if.slave bus,
    output logic [BUF_W-1:0]                     dct_buffer,
    output logic [CNT_W-1:0]                     dct_count,
    output logic                                 err_reserved
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DCT_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [BUF_W-1:0] codes_q, codes_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flush_pend_q, flush_pend_d;
    logic             err_q, err_d;
    logic             trc_on_q, trc_on_d;

    logic             code_ready_c;
    logic             accept;
    logic             flush_any;
    logic             pr_free;
    logic             pr_load;
    dct_pkt_t         pr_pkt;

    // Buffer-side next state; the incoming code is folded in before any packet load.
    always_comb begin
        state_d      = state_q;
        codes_d      = codes_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;
        err_d        = err_q;
        trc_on_d     = trc_on;
        pr_load      = 1'b0;
        pr_pkt       = '0;

        code_ready_c = trc_on & (state_q != ST_STALL);
        accept       = bus.code_valid & code_ready_c & (bus.code != DCT_RSV);
        flush_any    = flush_pend_q | bus.flush_req | (trc_on_q & ~trc_on);

        if (bus.code_valid & trc_on & (bus.code == DCT_RSV)) begin
            err_d = 1'b1;
        end

        if (accept) begin
            codes_d = {codes_q[BUF_W-CODE_W-1:0], bus.code};
            count_d = count_q + CNT_W'(1);
        end

        if (pr_free && ((count_d == CNT_FULL) || (flush_any && (count_d != '0)))) begin
            pr_load      = 1'b1;
            pr_pkt.count = count_d;
            pr_pkt.codes = codes_d;
            codes_d      = '0;
            count_d      = '0;
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_any & (count_d != '0);
        end

        if (pr_load) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_FULL) begin
            state_d = ST_STALL;
        end else if (count_d != '0) begin
            state_d = ST_FILL;
        end else begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            codes_q      <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            trc_on_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            codes_q      <= codes_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
            trc_on_q     <= trc_on_d;
        end
    end

    microarquitetura_gp3_oci_dct_pkt_reg #(
        .W (PKT_W)
    ) u_pkt_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pr_load),
        .load_data (pr_pkt),
        .out_ready (bus.pkt_ready),
        .out_valid (bus.pkt_valid),
        .out_data  (bus.pkt_data),
        .free_c    (pr_free)
    );

    assign bus.code_ready = code_ready_c;
    assign dct_buffer     = codes_q;
    assign dct_count      = count_q;
    assign err_reserved   = err_q;

endmodule
